// File: rtl/pe_seq_ctrl.sv
// Sequencer for one PE: loads K weight words, streams K activation vectors,
// then waits for the PE to echo CNN_FIN before pulsing done.

package pe_pkg;
  typedef enum logic [1:0] {
    INVALID = 2'd0,
    VALID   = 2'd1,
    CNN_FIN = 2'd2
  } PE_STATE;
endpackage

// One activation lane register; it only captures on an accepted RUN beat, so
// bubbles leave the previous vector on the bus.
module pe_seq_lane #(
  parameter int DATA_WID = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [DATA_WID-1:0] d,
  output logic [DATA_WID-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end
endmodule

module pe_seq_ctrl
  import pe_pkg::*;
#(
  parameter int DATA_WID = 8,
  parameter int ICP_NUM  = 4,
  parameter int ADDR_B   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_B-1:0]           cfg_len,
  input  logic [ICP_NUM-1:0]          cfg_wmask,
  input  logic                        cfg_reload,
  input  logic                        w_valid,
  input  logic [DATA_WID-1:0]         w_data,
  output logic                        w_ready,
  input  logic                        a_valid,
  input  logic [ICP_NUM*DATA_WID-1:0] a_data,
  output logic                        a_ready,
  output PE_STATE                     pe_state,
  output logic [ICP_NUM*DATA_WID-1:0] pe_a,
  output logic [DATA_WID-1:0]         pe_wrb_data,
  output logic [ADDR_B-1:0]           pe_wrb_addr,
  output logic [ICP_NUM-1:0]          pe_wrb,
  output logic [ADDR_B-1:0]           pe_rdb_addr,
  input  PE_STATE                     pe_out_state,
  output logic                        busy,
  output logic                        done
);
  localparam int CW = ADDR_B + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} st_t;

  st_t               st;
  logic [CW-1:0]     k;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nx;
  logic [ICP_NUM-1:0] wmask;
  logic              w_acc;
  logic              a_acc;
  logic              last;

  // Ready depends on state alone so the upstream valid never loops back.
  assign w_ready = (st == LOAD);
  assign a_ready = (st == RUN);
  assign w_acc   = w_valid & w_ready;
  assign a_acc   = a_valid & a_ready;
  assign cnt_nx  = cnt + CW'(1);
  assign last    = (cnt_nx == k);

  for (genvar i = 0; i < ICP_NUM; i++) begin : g_lane
    pe_seq_lane #(.DATA_WID(DATA_WID)) u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (a_acc),
      .d     (a_data[i*DATA_WID +: DATA_WID]),
      .q     (pe_a[i*DATA_WID +: DATA_WID])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= IDLE;
      k           <= '0;
      cnt         <= '0;
      wmask       <= '0;
      pe_state    <= INVALID;
      pe_wrb_data <= '0;
      pe_wrb_addr <= '0;
      pe_wrb      <= '0;
      pe_rdb_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      pe_wrb   <= '0;
      pe_state <= INVALID;
      done     <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            // A zero length encodes the full 2^ADDR_B buffer.
            k     <= {(cfg_len == '0), cfg_len};
            wmask <= cfg_wmask;
            cnt   <= '0;
            busy  <= 1'b1;
            st    <= cfg_reload ? LOAD : RUN;
          end
        end
        LOAD: begin
          if (w_acc) begin
            pe_wrb_data <= w_data;
            pe_wrb_addr <= cnt[ADDR_B-1:0];
            pe_wrb      <= wmask;
            if (last) begin
              cnt <= '0;
              st  <= RUN;
            end else begin
              cnt <= cnt_nx;
            end
          end
        end
        RUN: begin
          if (a_acc) begin
            pe_rdb_addr <= cnt[ADDR_B-1:0];
            pe_state    <= last ? CNN_FIN : VALID;
            cnt         <= cnt_nx;
            if (last) st <= DRAIN;
          end
        end
        DRAIN: begin
          if (pe_out_state == CNN_FIN) begin
            done <= 1'b1;
            busy <= 1'b0;
            st   <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Bench for pe_seq_ctrl: a table of jobs plus random jobs, each checked against
// a per-job event list built from the job parameters; a delay line stands in for the PE.
module tb_pe_seq_ctrl;
  import pe_pkg::*;

  localparam int DW = 8;
  localparam int IC = 4;
  localparam int AB = 4;
  localparam int PE_LAT = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [AB-1:0]   cfg_len;
  logic [IC-1:0]   cfg_wmask;
  logic            cfg_reload;
  logic            w_valid;
  logic [DW-1:0]   w_data;
  logic            w_ready;
  logic            a_valid;
  logic [IC*DW-1:0] a_data;
  logic            a_ready;
  PE_STATE         pe_state;
  logic [IC*DW-1:0] pe_a;
  logic [DW-1:0]   pe_wrb_data;
  logic [AB-1:0]   pe_wrb_addr;
  logic [IC-1:0]   pe_wrb;
  logic [AB-1:0]   pe_rdb_addr;
  PE_STATE         pe_out_state;
  logic            busy;
  logic            done;

  pe_seq_ctrl #(.DATA_WID(DW), .ICP_NUM(IC), .ADDR_B(AB)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len),
    .cfg_wmask(cfg_wmask), .cfg_reload(cfg_reload),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .pe_state(pe_state), .pe_a(pe_a), .pe_wrb_data(pe_wrb_data),
    .pe_wrb_addr(pe_wrb_addr), .pe_wrb(pe_wrb), .pe_rdb_addr(pe_rdb_addr),
    .pe_out_state(pe_out_state), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // PE stand-in: returns the input state PE_LAT cycles later.
  PE_STATE pipe [PE_LAT];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PE_LAT; i++) pipe[i] <= INVALID;
    end else begin
      pipe[0] <= pe_state;
      for (int i = 1; i < PE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign pe_out_state = pipe[PE_LAT-1];

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          tag;
    int          cy;
  } ev_t;

  typedef struct {
    int cy;
    int st;
    int ad;
    bit ar;
  } tr_t;

  ev_t wq[$];
  ev_t rq[$];
  tr_t tr[$];
  int  done_cnt, done_cyc, fin_cyc;
  bit  wr_seen;

  always @(negedge clk) begin
    if (pe_wrb != '0) wq.push_back('{int'(pe_wrb_addr), 32'(pe_wrb_data), int'(pe_wrb), cyc});
    if (pe_state != INVALID) rq.push_back('{int'(pe_rdb_addr), pe_a, int'(pe_state), cyc});
    tr.push_back('{cyc, int'(pe_state), int'(pe_rdb_addr), a_ready});
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (pe_out_state == CNN_FIN) fin_cyc = cyc;
    if (w_ready) wr_seen = 1'b1;
  end

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AB-1:0] len;
    logic [IC-1:0] wmask;
    bit            reload;
    bit            pattern;
    int            gap_at;
    int            bubble_pct;
    bit            poke;
    int            exp_w;
    int            exp_r;
  } job_t;

  task automatic run_job(input job_t j, input string nm);
    int K;
    logic [DW-1:0]    w [16];
    logic [IC*DW-1:0] a [16];
    ev_t ew[$];
    ev_t er[$];
    int wi, ai, gap, n, idx;
    bit gapped_now, poked, wacc, aacc;
    K = (j.len == '0) ? 16 : int'(j.len);
    for (int i = 0; i < 16; i++) begin
      if (j.pattern) begin
        w[i] = 8'(i + 1);
        a[i] = {8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i), 8'(i)};
      end else begin
        w[i] = 8'($urandom);
        a[i] = $urandom;
      end
    end
    // Reference event lists straight from the job description.
    for (int i = 0; i < K; i++) begin
      if (j.reload) ew.push_back('{i, 32'(w[i]), int'(j.wmask), 0});
      er.push_back('{i, a[i], (i == K-1) ? int'(CNN_FIN) : int'(VALID), 0});
    end
    wq.delete(); rq.delete(); tr.delete();
    done_cnt = 0; done_cyc = -1; fin_cyc = -1; wr_seen = 1'b0;

    @(posedge clk); #1;
    start = 1'b1; cfg_len = j.len; cfg_wmask = j.wmask; cfg_reload = j.reload;
    @(posedge clk); #1;
    start = 1'b0;
    check({nm, " busy after start"}, 32'(busy), 1);
    check({nm, " w_ready after start"}, 32'(w_ready), 32'(j.reload));
    check({nm, " a_ready after start"}, 32'(a_ready), 32'(!j.reload));

    wi = 0; ai = 0; gap = 0; n = 0; poked = 1'b0;
    while (((j.reload && wi < K) || ai < K) && n < 600) begin
      w_valid = j.reload && (wi < K) && (int'($urandom_range(99)) >= j.bubble_pct);
      w_data  = w_valid ? w[wi] : 8'($urandom);
      gapped_now = (ai == j.gap_at) && (gap < 2) && a_ready;
      if (gapped_now) gap++;
      a_valid = (ai < K) && !gapped_now && (int'($urandom_range(99)) >= j.bubble_pct);
      a_data  = a_valid ? a[ai] : $urandom;
      start = j.poke && a_ready && (ai == 2) && !poked;
      if (start) begin
        poked = 1'b1;
        cfg_len = 4'd3; cfg_wmask = ~j.wmask; cfg_reload = ~j.reload;
      end
      wacc = w_valid && w_ready;
      aacc = a_valid && a_ready;
      @(posedge clk); #1;
      if (wacc) wi++;
      if (aacc) ai++;
      n++;
    end
    w_valid = 1'b0; a_valid = 1'b0; start = 1'b0;
    if (n >= 600) check({nm, " stream timeout"}, 1, 0);

    n = 0;
    while (done_cnt == 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == 0) check({nm, " done timeout"}, 0, 1);
    repeat (5) @(posedge clk);
    #1;
    check({nm, " busy idle after done"}, 32'(busy), 0);
    check({nm, " done pulses"}, done_cnt, 1);
    check({nm, " done one cycle after PE fin"}, done_cyc, fin_cyc + 1);
    check({nm, " w_ready seen"}, 32'(wr_seen), 32'(j.reload));
    check({nm, " write count"}, wq.size(), j.exp_w);
    check({nm, " read count"}, rq.size(), j.exp_r);
    for (int i = 0; i < ew.size() && i < wq.size(); i++) begin
      check($sformatf("%s wr%0d addr", nm, i), wq[i].addr, ew[i].addr);
      check($sformatf("%s wr%0d data", nm, i), wq[i].data, ew[i].data);
      check($sformatf("%s wr%0d mask", nm, i), wq[i].tag, ew[i].tag);
    end
    for (int i = 0; i < er.size() && i < rq.size(); i++) begin
      check($sformatf("%s rd%0d addr", nm, i), rq[i].addr, er[i].addr);
      check($sformatf("%s rd%0d vec", nm, i), rq[i].data, er[i].data);
      check($sformatf("%s rd%0d state", nm, i), rq[i].tag, er[i].tag);
    end
    // The cycle showing the last write must already have a_ready up, and
    // no read may appear before the following cycle.
    if (j.reload && wq.size() > 0 && rq.size() > 0) begin
      for (int i = 0; i < tr.size(); i++)
        if (tr[i].cy == wq[wq.size()-1].cy)
          check({nm, " a_ready with last write"}, 32'(tr[i].ar), 1);
      check({nm, " first read after last write"},
            32'(rq[0].cy > wq[wq.size()-1].cy), 1);
    end
    if (j.gap_at > 0) begin
      idx = -1;
      for (int i = 0; i < tr.size(); i++)
        if (idx < 0 && tr[i].st != int'(INVALID) && tr[i].ad == j.gap_at - 1) idx = i;
      if (idx < 0 || idx + 3 >= tr.size()) begin
        check({nm, " bubble trace found"}, 0, 1);
      end else begin
        for (int b = 1; b <= 2; b++) begin
          check($sformatf("%s bubble%0d state", nm, b), tr[idx+b].st, int'(INVALID));
          check($sformatf("%s bubble%0d addr held", nm, b), tr[idx+b].ad, j.gap_at - 1);
        end
        check({nm, " resume state"}, tr[idx+3].st, int'(VALID));
        check({nm, " resume addr"}, tr[idx+3].ad, j.gap_at);
      end
    end
  endtask

  job_t tbl [6];
  job_t rj;

  initial begin
    tbl[0] = '{4'd9, 4'b1111, 1'b1, 1'b1, -1, 0, 1'b0, 9, 9};
    tbl[1] = '{4'd9, 4'b1111, 1'b1, 1'b1,  4, 0, 1'b0, 9, 9};
    tbl[2] = '{4'd9, 4'b1111, 1'b0, 1'b1, -1, 0, 1'b0, 0, 9};
    tbl[3] = '{4'd0, 4'b0101, 1'b1, 1'b0, -1, 0, 1'b0, 16, 16};
    tbl[4] = '{4'd1, 4'b0010, 1'b1, 1'b0, -1, 0, 1'b0, 1, 1};
    tbl[5] = '{4'd5, 4'b1000, 1'b1, 1'b0, -1, 0, 1'b1, 5, 5};

    reset = 1'b1; start = 1'b0; cfg_len = '0; cfg_wmask = '0; cfg_reload = 1'b0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 0);
    check("reset w_ready", 32'(w_ready), 0);
    check("reset a_ready", 32'(a_ready), 0);
    check("reset pe_state", int'(pe_state), int'(INVALID));
    check("reset done", 32'(done), 0);
    check("reset pe_wrb", 32'(pe_wrb), 0);
    reset = 1'b0;

    for (int t = 0; t < 6; t++) run_job(tbl[t], $sformatf("job%0d", t));

    // Reset in the middle of LOAD, right after the 5th weight write shows up.
    @(posedge clk); #1;
    start = 1'b1; cfg_len = 4'd9; cfg_wmask = 4'b1111; cfg_reload = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w_data = 8'(8'hA0 + i);
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    check("midload write visible", 32'(pe_wrb), 32'hF);
    #2 reset = 1'b1;
    #1;
    check("midload rst busy", 32'(busy), 0);
    check("midload rst w_ready", 32'(w_ready), 0);
    check("midload rst pe_wrb", 32'(pe_wrb), 0);
    check("midload rst wrb_addr", 32'(pe_wrb_addr), 0);
    check("midload rst wrb_data", 32'(pe_wrb_data), 0);
    check("midload rst pe_a", pe_a, 0);
    check("midload rst rdb_addr", 32'(pe_rdb_addr), 0);
    check("midload rst pe_state", int'(pe_state), int'(INVALID));
    check("midload rst done", 32'(done), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_job(tbl[0], "after_reset");

    for (int r = 0; r < 8; r++) begin
      rj.len        = 4'($urandom_range(15));
      rj.wmask      = 4'($urandom_range(15, 1));
      rj.reload     = 1'($urandom_range(1));
      rj.pattern    = 1'b0;
      rj.gap_at     = -1;
      rj.bubble_pct = 30;
      rj.poke       = 1'($urandom_range(1));
      rj.exp_r      = (rj.len == '0) ? 16 : int'(rj.len);
      rj.exp_w      = rj.reload ? rj.exp_r : 0;
      // The mid-RUN start needs at least 3 vectors to land inside RUN.
      if (rj.exp_r < 3) rj.poke = 1'b0;
      run_job(rj, $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
